// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC hardwired control sequencer:
// opcode encodings, sequencer states and the opcode classes used for decode.
package mini_src_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_ALU2,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Classes whose execute phase runs past T3.
    function automatic logic needs_t4(op_class_t c);
        return (c == CLS_ALU3) || (c == CLS_ALU2) || (c == CLS_MULDIV);
    endfunction

    function automatic logic needs_t5(op_class_t c);
        return (c == CLS_ALU3) || (c == CLS_MULDIV);
    endfunction

endpackage

// File: rtl/control_unit_opcode_class.sv
// Combinational opcode classifier: maps IR[31:27] onto exactly one
// execution class so the sequencer only has to reason about six cases.
module opcode_class
    import mini_src_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:       op_class = CLS_ALU3;
            OP_NEG, OP_NOT:                        op_class = CLS_ALU2;
            OP_MUL, OP_DIV:                        op_class = CLS_MULDIV;
            OP_NOP:                                op_class = CLS_NOP;
            OP_HALT:                               op_class = CLS_HALT;
            default:                               op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch via PC/MAR/MDR,
// then per-class register-transfer strobes. Outputs decode from state and ir.
module control_unit
    import mini_src_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    input  logic           stop,
    output logic           PC_out,
    output logic           Zlow_out,
    output logic           Zhigh_out,
    output logic           MDR_out,
    output logic           R_out,
    output logic           PC_in,
    output logic           IncPC,
    output logic           MAR_in,
    output logic           MDR_in,
    output logic           Read,
    output logic           IR_in,
    output logic           Y_in,
    output logic           Z_in,
    output logic           HI_in,
    output logic           LO_in,
    output logic           R_in,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           illegal
);

    state_t         state_q;
    state_t         state_d;
    op_class_t      op_class;
    logic [OPW-1:0] opcode;

    // Register fields are consumed by the datapath's select-and-encode logic.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[26:0];

    assign opcode = ir[31:27];

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_T0;
            ST_T0:   state_d = stop ? ST_HALT : ST_T1;
            ST_T1:   state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op_class == CLS_HALT) begin
                    state_d = ST_HALT;
                end else if (needs_t4(op_class)) begin
                    state_d = ST_T4;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T4:   state_d = needs_t5(op_class) ? ST_T5 : ST_T0;
            ST_T5:   state_d = (op_class == CLS_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are pure Moore decode so an asynchronous clear silences them at once.
    always_comb begin
        PC_out    = 1'b0;
        Zlow_out  = 1'b0;
        Zhigh_out = 1'b0;
        MDR_out   = 1'b0;
        R_out     = 1'b0;
        PC_in     = 1'b0;
        IncPC     = 1'b0;
        MAR_in    = 1'b0;
        MDR_in    = 1'b0;
        Read      = 1'b0;
        IR_in     = 1'b0;
        Y_in      = 1'b0;
        Z_in      = 1'b0;
        HI_in     = 1'b0;
        LO_in     = 1'b0;
        R_in      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        alu_op    = '0;
        illegal   = 1'b0;
        run       = (state_q != ST_IDLE) && (state_q != ST_HALT);

        case (state_q)
            ST_T0: begin
                PC_out = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
                Z_in   = 1'b1;
            end
            ST_T1: begin
                Zlow_out = 1'b1;
                PC_in    = 1'b1;
                Read     = 1'b1;
                MDR_in   = 1'b1;
            end
            ST_T2: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
            end
            ST_T3: begin
                case (op_class)
                    CLS_ALU3: begin
                        Grb   = 1'b1;
                        R_out = 1'b1;
                        Y_in  = 1'b1;
                    end
                    CLS_ALU2: begin
                        Grb    = 1'b1;
                        R_out  = 1'b1;
                        Z_in   = 1'b1;
                        alu_op = opcode;
                    end
                    CLS_MULDIV: begin
                        Gra   = 1'b1;
                        R_out = 1'b1;
                        Y_in  = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_ALU3: begin
                        Grc    = 1'b1;
                        R_out  = 1'b1;
                        Z_in   = 1'b1;
                        alu_op = opcode;
                    end
                    CLS_ALU2: begin
                        Zlow_out = 1'b1;
                        Gra      = 1'b1;
                        R_in     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        Grb    = 1'b1;
                        R_out  = 1'b1;
                        Z_in   = 1'b1;
                        alu_op = opcode;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CLS_ALU3: begin
                        Zlow_out = 1'b1;
                        Gra      = 1'b1;
                        R_in     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        Zlow_out = 1'b1;
                        LO_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (op_class == CLS_MULDIV) begin
                    Zhigh_out = 1'b1;
                    HI_in     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer that replaces bench-driven control strobes with a cycle-accurate Moore FSM. Fetches each instruction via PC/MAR/MDR and loads IR. Decodes IR[31:27] and sequences the datapath register-transfer strobes for ALU-class instructions (3-operand, 2-operand, mul/div), nop, and halt. Sits beside `datapath`; its outputs connect one-to-one to the datapath's control inputs.

## Interface
- `OPW`, 5, opcode width (IR[31:27]); also the width of `alu_op`.
- `clk`  in  1  system clock; all state changes on posedge.
- `clr`  in  1  asynchronous, active-low reset.
- `ir`  in  32  IR contents; Ra = [26:23], Rb = [22:19], Rc = [18:15].
- `mem_ready`  in  1  memory read data valid on Mdatain.
- `stop`  in  1  halt request, sampled only at instruction boundary.
- `PC_out, Zlow_out, Zhigh_out, MDR_out, R_out`  out  1 each  bus drive selects.
- `PC_in, IncPC, MAR_in, MDR_in, Read, IR_in, Y_in, Z_in, HI_in, LO_in, R_in`  out  1 each  register load and memory strobes.
- `Gra, Grb, Grc`  out  1 each  select-and-encode field selects; at most one high.
- `alu_op`  out  OPW  ALU operation; equals `ir[31:27]` when `Z_in` is high with an ALU op, else 0.
- `run`  out  1  high while executing; low in IDLE and HALT.
- `illegal`  out  1  one-cycle pulse in T3 for an undefined opcode.

## Operation
- Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011. All others are illegal.
- States: IDLE, T0–T6, HALT. Outputs are decoded purely from the state register plus `ir`. Any strobe not listed below is 0.
- IDLE: all outputs 0, `run`=0. Advances to T0 on the first posedge after `clr` deasserts.
- T0: PC_out, MAR_in, IncPC, Z_in. If `stop`=1 on this edge, next state is HALT; otherwise T1.
- T1: Zlow_out, PC_in, Read, MDR_in. Holds in T1 while `mem_ready`=0; advances to T2 on the edge where `mem_ready`=1.
- T2: MDR_out, IR_in → T3.
- 3-operand ALU ops (add through rol):
  - T3: Grb, R_out, Y_in.
  - T4: Grc, R_out, Z_in, alu_op.
  - T5: Zlow_out, Gra, R_in → T0.
- neg, not:
  - T3: Grb, R_out, Z_in, alu_op.
  - T4: Zlow_out, Gra, R_in → T0.
- mul, div:
  - T3: Gra, R_out, Y_in.
  - T4: Grb, R_out, Z_in, alu_op.
  - T5: Zlow_out, LO_in.
  - T6: Zhigh_out, HI_in → T0.
- nop: T3 drives no strobes → T0.
- Illegal opcode: T3 drives `illegal`=1 only → T0. Execution continues like nop.
- halt: T3 → HALT.
- HALT: all strobes 0, `run`=0. Absorbing; only `clr` exits.

## Timing
- Each state lasts one clock. Strobes are high for that entire cycle; the datapath captures on the closing posedge.
- Instruction latency with `mem_ready` tied high:
  - 3-operand: 6 cycles.
  - neg/not: 5 cycles.
  - mul/div: 7 cycles.
  - nop/illegal: 4 cycles.
- Each cycle of low `mem_ready` adds one cycle in T1.
- Decode uses `ir` starting in T3, since IR is loaded at the end of T2. `ir` is don't-care in T0–T2.
- Reset values: state IDLE, every output 0, `alu_op`=0, `run`=0. `clr` low mid-instruction forces IDLE asynchronously and zeroes all outputs immediately. No partial transfer completes.
- `stop` is ignored outside T0. If `stop` and `mem_ready` change in the same cycle, each is evaluated only in its own state.
- `Gra`/`Grb`/`Grc` are mutually exclusive in every state, and `R_in`/`R_out` are never both high. The bench asserts both.

## Structure
- Package `mini_src_pkg` holds: opcode constants, the state enum (IDLE, T0–T6, HALT), and `OPW`.
- One sub-module, `opcode_class` (combinational). Maps `ir[31:27]` to exactly one class: ALU3, ALU2, MULDIV, NOP, HALT, ILLEGAL. `control_unit` instantiates it once.

## Test plan
- Reset release with `mem_ready`=1 and IR = 0x489A8000 (shl R1,R3,R5):
  - States IDLE→T0→T1→T2→T3→T4→T5→T0.
  - T3: Grb+R_out+Y_in.
  - T4: Grc+R_out+Z_in with alu_op=01001.
  - T5: Zlow_out+Gra+R_in.
- Instruction mul (IR[31:27]=01111):
  - T5: Zlow_out+LO_in; T6: Zhigh_out+HI_in.
  - Total 7 cycles T0-to-T0.
- `mem_ready` held low for 3 cycles in T1:
  - FSM holds T1 for 4 cycles with Read=1 and MDR_in=1 throughout, then enters T2.
- Opcode 11111:
  - `illegal` pulses for exactly 1 cycle in T3; next state T0.
  - halt opcode, and separately `stop`=1 at T0, each enter HALT with `run`=0 and all strobes 0 for 10+ cycles.
- `clr` driven low mid-T4 of an add:
  - All outputs 0 within the same cycle, with no clock needed.
  - After release, IDLE for one cycle, then T0.
